// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter serializing requester A/B accesses onto one data memory
// Define MEM_ARB_FIXED_PRIO_EN to make port A always win simultaneous requests (default: round-robin).
module mem_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_A,
    input  logic              REQ_B,
    input  logic              WE_A,
    input  logic              WE_B,
    input  logic [ADDR_W-1:0] ADDR_A,
    input  logic [ADDR_W-1:0] ADDR_B,
    input  logic [DATA_W-1:0] WDATA_A,
    input  logic [DATA_W-1:0] WDATA_B,
    output logic              ACK_A,
    output logic              ACK_B,
    output logic [DATA_W-1:0] RDATA_A,
    output logic [DATA_W-1:0] RDATA_B,
    output logic              ERR_A,
    output logic              ERR_B,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDR_OUT,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              any_req;
    logic              grant_b;
    logic              sel_b;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              in_range;

    assign any_req  = REQ_A | REQ_B;
    assign in_range = (lat_addr < ADDR_W'(DEPTH));

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign grant_b = ~REQ_A;
`else
    logic last_b;

    // B wins only when A is idle or A was the port served last
    assign grant_b = REQ_B & (~REQ_A | ~last_b);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            last_b <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_b <= grant_b;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sel_b     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == IDLE && any_req) begin
            sel_b     <= grant_b;
            lat_we    <= grant_b ? WE_B    : WE_A;
            lat_addr  <= grant_b ? ADDR_B  : ADDR_A;
            lat_wdata <= grant_b ? WDATA_B : WDATA_A;
        end
    end

    // Memory port is live only during ACCESS; an out-of-range address gets no strobe
    always_comb begin
        MEM_READ     = 1'b0;
        MEM_WRITE    = 1'b0;
        MEM_ADDR_OUT = '0;
        MEM_WDATA    = '0;
        if (state == ACCESS) begin
            MEM_ADDR_OUT = lat_addr;
            MEM_WDATA    = lat_wdata;
            if (in_range) begin
                MEM_WRITE = lat_we;
                MEM_READ  = ~lat_we;
            end
        end
    end

    // ACK/ERR register at the edge ending DONE, so a reset in DONE suppresses the ACK
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ACK_A   <= 1'b0;
            ACK_B   <= 1'b0;
            ERR_A   <= 1'b0;
            ERR_B   <= 1'b0;
            RDATA_A <= '0;
            RDATA_B <= '0;
        end else begin
            ACK_A <= (state == DONE) & ~sel_b;
            ACK_B <= (state == DONE) &  sel_b;
            ERR_A <= (state == DONE) & ~sel_b & ~in_range;
            ERR_B <= (state == DONE) &  sel_b & ~in_range;
            if (state == ACCESS && (!lat_we || !in_range)) begin
                if (sel_b) begin
                    RDATA_B <= in_range ? MEM_RDATA : '0;
                end else begin
                    RDATA_A <= in_range ? MEM_RDATA : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter against a transaction-level reference model
module tb_mem_arbiter;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 64;
    localparam int DEPTH  = 16;
    localparam int IW     = $clog2(DEPTH);

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              REQ_A = 1'b0;
    logic              REQ_B = 1'b0;
    logic              WE_A = 1'b0;
    logic              WE_B = 1'b0;
    logic [ADDR_W-1:0] ADDR_A = '0;
    logic [ADDR_W-1:0] ADDR_B = '0;
    logic [DATA_W-1:0] WDATA_A = '0;
    logic [DATA_W-1:0] WDATA_B = '0;
    logic              ACK_A, ACK_B, ERR_A, ERR_B;
    logic [DATA_W-1:0] RDATA_A, RDATA_B;
    logic              MEM_READ, MEM_WRITE;
    logic [ADDR_W-1:0] MEM_ADDR_OUT;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA;

    mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .WE_A(WE_A), .WE_B(WE_B),
        .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .WDATA_A(WDATA_A), .WDATA_B(WDATA_B),
        .ACK_A(ACK_A), .ACK_B(ACK_B), .RDATA_A(RDATA_A), .RDATA_B(RDATA_B),
        .ERR_A(ERR_A), .ERR_B(ERR_B),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDR_OUT(MEM_ADDR_OUT), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;
    int n_rd    = 0;
    bit load_en = 1'b1;
    bit mon_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] init_val(input int i);
        return (i == 0) ? 64'h5 : {32'(i), 32'hC0DE_0000 + 32'(i)};
    endfunction

    // Environment memory: asynchronous read, written by the DUT strobes
    logic [DATA_W-1:0] mem [DEPTH];
    assign MEM_RDATA = (MEM_ADDR_OUT < ADDR_W'(DEPTH)) ? mem[MEM_ADDR_OUT[IW-1:0]] : '0;

    always @(posedge CLK) begin
        if (load_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
        end else if (MEM_WRITE && MEM_ADDR_OUT < ADDR_W'(DEPTH)) begin
            mem[MEM_ADDR_OUT[IW-1:0]] <= MEM_WDATA;
        end
    end

    // Reference model: one grant per 3 edges, tie rule from the configuration,
    // answer visible after the edge two after the grant.
    typedef struct {
        bit                port;
        bit                err;
        logic [DATA_W-1:0] rdata;
        int                ack_edge;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] held [2];
    int                edge_cnt  = 0;
    int                next_free = 0;
    bit                m_last_b  = 1'b1;

    always @(posedge CLK) begin
        bit                win_b;
        bit                we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd;
        exp_t              e;
        edge_cnt++;
        if (load_en) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        end
        if (!RST_N) begin
            for (int i = exp_q.size() - 1; i >= 0; i--)
                if (exp_q[i].ack_edge >= edge_cnt) exp_q.delete(i);
            next_free = edge_cnt + 1;
            m_last_b  = 1'b1;
            held[0]   = '0;
            held[1]   = '0;
        end else if (edge_cnt >= next_free && (REQ_A || REQ_B)) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            win_b = !REQ_A;
`else
            win_b    = (REQ_A && REQ_B) ? !m_last_b : REQ_B;
            m_last_b = win_b;
`endif
            we = win_b ? WE_B    : WE_A;
            a  = win_b ? ADDR_B  : ADDR_A;
            wd = win_b ? WDATA_B : WDATA_A;
            e.port = win_b;
            e.err  = (a >= ADDR_W'(DEPTH));
            if (e.err)   held[win_b] = '0;
            else if (we) ref_mem[a[IW-1:0]] = wd;
            else         held[win_b] = ref_mem[a[IW-1:0]];
            e.rdata    = held[win_b];
            e.ack_edge = edge_cnt + 2;
            exp_q.push_back(e);
            next_free = edge_cnt + 3;
        end
    end

    // Monitor: pops the scoreboard whenever an ACK appears
    always @(negedge CLK) begin
        exp_t e;
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].ack_edge < edge_cnt) begin
                e = exp_q.pop_front();
                chk("ack_missing", 64'(edge_cnt), 64'(e.ack_edge));
            end
            if (MEM_READ || MEM_WRITE) begin
                chk("strobe_exclusive", 64'(MEM_READ & MEM_WRITE), 64'd0);
                chk("strobe_addr_in_range", 64'(MEM_ADDR_OUT < ADDR_W'(DEPTH)), 64'd1);
                if (MEM_WRITE) n_wr++;
                if (MEM_READ)  n_rd++;
            end
            if (ACK_A || ACK_B) begin
                chk("single_ack", 64'(ACK_A & ACK_B), 64'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got ACK_A=%0b ACK_B=%0b expected no ack", ACK_A, ACK_B);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_port", 64'(ACK_B), 64'(e.port));
                    chk("ack_edge", 64'(edge_cnt), 64'(e.ack_edge));
                    chk("err", 64'(e.port ? ERR_B : ERR_A), 64'(e.err));
                    chk("rdata", e.port ? RDATA_B : RDATA_A, e.rdata);
                end
            end else begin
                chk("err_without_ack", 64'(ERR_A | ERR_B), 64'd0);
            end
        end
    end

    task automatic set_port(input int p, input bit req, input bit we,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        if (p == 0) begin REQ_A = req; WE_A = we; ADDR_A = a; WDATA_A = wd; end
        else        begin REQ_B = req; WE_B = we; ADDR_B = a; WDATA_B = wd; end
    endtask

    task automatic do_op(input int p, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd);
        int wr0;
        int rd0;
        bit got;
        bit inr;
        wr0 = n_wr;
        rd0 = n_rd;
        got = 1'b0;
        inr = (a < ADDR_W'(DEPTH));
        @(negedge CLK);
        set_port(p, 1'b1, we, a, wd);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (p == 0 ? ACK_A : ACK_B) got = 1'b1;
        end
        set_port(p, 1'b0, 1'b0, '0, '0);
        chk("op_acked", 64'(got), 64'd1);
        chk("write_strobes", 64'(n_wr - wr0), 64'(we & inr));
        chk("read_strobes", 64'(n_rd - rd0), 64'(!we & inr));
    endtask

    task automatic drive_random(input int p);
        logic [ADDR_W-1:0] a;
        a = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : ADDR_W'($urandom_range(0, DEPTH + 2));
        set_port(p, 1'b1, 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    endtask

    task automatic run_ports(input int na, input int nb, input bit hold);
        int left[2];
        bit act[2];
        int budget;
        left[0] = na; left[1] = nb;
        act[0] = 1'b0; act[1] = 1'b0;
        budget = (na + nb) * 12 + 50;
        while ((left[0] > 0 || left[1] > 0 || act[0] || act[1]) && budget > 0) begin
            @(negedge CLK);
            budget--;
            for (int p = 0; p < 2; p++) begin
                if (act[p] && (p == 0 ? ACK_A : ACK_B)) begin
                    left[p]--;
                    act[p] = 1'b0;
                end
                if (!act[p] && left[p] > 0 && (hold || $urandom_range(0, 2) == 0)) begin
                    act[p] = 1'b1;
                    drive_random(p);
                end else if (!act[p]) begin
                    set_port(p, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        chk("run_ports_finished", 64'(budget > 0), 64'd1);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        bit got;
        @(negedge CLK);
        @(negedge CLK);
        mon_en = 1'b1;
        chk("reset_ack_a", 64'(ACK_A), 64'd0);
        chk("reset_ack_b", 64'(ACK_B), 64'd0);
        chk("reset_err_a", 64'(ERR_A), 64'd0);
        chk("reset_err_b", 64'(ERR_B), 64'd0);
        chk("reset_rdata_a", RDATA_A, 64'd0);
        chk("reset_rdata_b", RDATA_B, 64'd0);
        chk("reset_mem_read", 64'(MEM_READ), 64'd0);
        chk("reset_mem_write", 64'(MEM_WRITE), 64'd0);
        chk("reset_mem_addr", MEM_ADDR_OUT, 64'd0);
        chk("reset_mem_wdata", MEM_WDATA, 64'd0);
        load_en = 1'b0;
        RST_N   = 1'b1;

        do_op(0, 1'b1, 64'd3, 64'hDEAD);
        do_op(0, 1'b0, 64'd3, 64'd0);
        chk("rdata_a_readback", RDATA_A, 64'hDEAD);
        do_op(1, 1'b0, 64'd0, 64'd0);
        chk("rdata_b_preload", RDATA_B, 64'h5);
        do_op(0, 1'b1, 64'(DEPTH), 64'h1234);
        chk("rdata_a_oor", RDATA_A, 64'd0);

        // Reset landing in the DONE cycle of a B read; B keeps requesting
        @(negedge CLK);
        set_port(1, 1'b1, 1'b0, 64'd7, 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        chk("no_ack_after_reset_in_done", 64'(ACK_B), 64'd0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (ACK_B) got = 1'b1;
        end
        set_port(1, 1'b0, 1'b0, '0, '0);
        chk("held_b_served_after_reset", 64'(got), 64'd1);
        chk("rdata_b_after_reset", RDATA_B, init_val(7));

        pulse_reset();
        run_ports(2, 2, 1'b1);
        run_ports(150, 150, 1'b0);

        repeat (6) @(negedge CLK);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("mem_%0d", i), mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
